// File: rtl/pong_ball_engine_if.sv
// pong_ball_engine_if
//   Groups the game-logic stage signals between the frame/paddle source and the
//   ball engine.
//   Ports (signals):
//     start        game enable level
//     frame_tick   one-clk pulse per video frame
//     paddle1_y    left paddle top Y
//     paddle2_y    right paddle top Y
//     ball_x       ball left X (registered)
//     ball_y       ball top Y (registered)
//     p1_score     left player score
//     p2_score     right player score
//     state        game state: 00 IDLE, 01 SERVE, 10 PLAY, 11 DONE
//     score_pulse  one-clk pulse when a point is awarded
//   Modports: master drives start/frame_tick/paddles, slave is the engine.
//
// Transfer rule: there is no valid/ready pair here. frame_tick acts as the
// valid qualifier for start and the paddle inputs; the engine is always ready,
// so every clk edge with frame_tick=1 consumes one frame of input and the
// outputs reflect it one clk later.
interface pong_ball_engine_if;
    logic       start;
    logic       frame_tick;
    logic [8:0] paddle1_y;
    logic [8:0] paddle2_y;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] state;
    logic       score_pulse;

    modport master (
        output start, frame_tick, paddle1_y, paddle2_y,
        input  ball_x, ball_y, p1_score, p2_score, state, score_pulse
    );

    modport slave (
        input  start, frame_tick, paddle1_y, paddle2_y,
        output ball_x, ball_y, p1_score, p2_score, state, score_pulse
    );
endinterface

// File: rtl/pong_ball_engine.sv
// pong_ball_engine
//   Frame-rate game logic for pong: ball position and direction, wall and
//   paddle collisions, scoring and the IDLE/SERVE/PLAY/DONE state machine.
//   Ports:
//     clk    pixel-domain clock
//     reset  asynchronous, active-high
//     bus    pong_ball_engine_if.slave (start, frame_tick, paddle1_y,
//            paddle2_y in; ball_x, ball_y, p1_score, p2_score, state,
//            score_pulse out)
//   Optional feature: define BALL_SPEEDUP_EN to add one pixel to the
//   horizontal step on every paddle reflection (saturating at X_STEP_MAX).
//   The state output doubles as the FSM debug view.
module pong_ball_engine #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_W    = 10,
    parameter int PADDLE_H    = 50,
    parameter int P1_PADDLE_X = 0,
    parameter int P2_PADDLE_X = 630,
    parameter int X_STEP      = 4,
    parameter int Y_STEP      = 2,
    parameter int X_STEP_MAX  = 8,
    parameter int WIN_SCORE   = 10,
    parameter int SERVE_DELAY = 60
) (
    input logic              clk,
    input logic              reset,
    pong_ball_engine_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int CNT_W  = $clog2(SERVE_DELAY + 1);
    // Step register is sized for the ceiling so both builds share one width.
    localparam int STEP_W = $clog2(X_STEP_MAX + 1);

    localparam logic [9:0]        CENTER_X = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [8:0]        CENTER_Y = 9'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [STEP_W-1:0] STEP0    = STEP_W'(X_STEP);
    localparam logic [3:0]        WIN4     = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SERVE_DELAY - 1);

    // 11-bit constants so that no sum or compare below can wrap.
    localparam logic [10:0] X_L  = 11'(P1_PADDLE_X + PADDLE_W);
    localparam logic [10:0] X_R  = 11'(P2_PADDLE_X - BALL_SIZE);
    localparam logic [10:0] BS   = 11'(BALL_SIZE);
    localparam logic [10:0] PH   = 11'(PADDLE_H);
    localparam logic [10:0] YS   = 11'(Y_STEP);
    localparam logic [10:0] SW   = 11'(SCREEN_W);
    localparam logic [10:0] SH   = 11'(SCREEN_H);

    state_t              state_q, state_d;
    logic [9:0]          ball_x_q, ball_x_d;
    logic [8:0]          ball_y_q, ball_y_d;
    logic [3:0]          p1_q, p1_d, p2_q, p2_d;
    logic                pulse_q, pulse_d;
    logic                dir_x_q, dir_x_d;   // 1 = right
    logic                dir_y_q, dir_y_d;   // 1 = down
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STEP_W-1:0]   step_q, step_d;

    logic [10:0] bx, by, st, py1, py2;
    logic        hit_l, hit_r, miss_l, miss_r;

    assign bx  = 11'(ball_x_q);
    assign by  = 11'(ball_y_q);
    assign st  = 11'(step_q);
    assign py1 = 11'(bus.paddle1_y);
    assign py2 = 11'(bus.paddle2_y);

    // Paddle windows cover exactly one step's worth of travel in front of
    // each paddle face, so the ball cannot skip through a paddle.
    assign hit_l  = !dir_x_q && (bx >= X_L) && (bx < X_L + st)
                    && (by + BS > py1) && (by < py1 + PH);
    assign hit_r  = dir_x_q && (bx <= X_R) && (bx + st > X_R)
                    && (by + BS > py2) && (by < py2 + PH);
    assign miss_l = !dir_x_q && !hit_l && (bx < st);
    assign miss_r = dir_x_q && !hit_r && (bx + BS + st > SW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ball_x_q <= CENTER_X;
            ball_y_q <= CENTER_Y;
            p1_q     <= 4'd0;
            p2_q     <= 4'd0;
            pulse_q  <= 1'b0;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            cnt_q    <= '0;
            step_q   <= STEP0;
        end else begin
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            pulse_q  <= pulse_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        pulse_d  = 1'b0;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        cnt_d    = cnt_q;
        step_d   = step_q;

        // Dropping start abandons the game on any edge, ahead of frame_tick.
        if (!bus.start && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            ball_x_d = CENTER_X;
            ball_y_d = CENTER_Y;
            p1_d     = 4'd0;
            p2_d     = 4'd0;
            dir_x_d  = 1'b1;
            cnt_d    = '0;
            step_d   = STEP0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ball_x_d = CENTER_X;
                    ball_y_d = CENTER_Y;
                    p1_d     = 4'd0;
                    p2_d     = 4'd0;
                    dir_x_d  = 1'b1;   // first serve after IDLE goes right
                    cnt_d    = '0;
                    step_d   = STEP0;
                    if (bus.frame_tick && bus.start) begin
                        state_d = ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (bus.frame_tick) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_PLAY;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (bus.frame_tick) begin
                        if (miss_l || miss_r) begin
                            // dir_y is deliberately left as it was.
                            pulse_d  = 1'b1;
                            ball_x_d = CENTER_X;
                            ball_y_d = CENTER_Y;
                            step_d   = STEP0;
                            cnt_d    = '0;
                            state_d  = ST_SERVE;
                            if (miss_l) begin
                                p2_d    = (p2_q >= WIN4) ? WIN4 : p2_q + 4'd1;
                                dir_x_d = 1'b0;
                                if (p2_d == WIN4) state_d = ST_DONE;
                            end else begin
                                p1_d    = (p1_q >= WIN4) ? WIN4 : p1_q + 4'd1;
                                dir_x_d = 1'b1;
                                if (p1_d == WIN4) state_d = ST_DONE;
                            end
                        end else begin
                            if (hit_l || hit_r) begin
                                ball_x_d = hit_l ? 10'(X_L) : 10'(X_R);
                                dir_x_d  = hit_l;
`ifdef BALL_SPEEDUP_EN
                                if (step_q < STEP_W'(X_STEP_MAX)) begin
                                    step_d = step_q + 1'b1;
                                end
`endif
                            end else if (dir_x_q) begin
                                ball_x_d = 10'(bx + st);
                            end else begin
                                ball_x_d = 10'(bx - st);
                            end

                            if (!dir_y_q) begin
                                if (by < YS) begin
                                    ball_y_d = 9'd0;
                                    dir_y_d  = 1'b1;
                                end else begin
                                    ball_y_d = 9'(by - YS);
                                end
                            end else begin
                                if (by + BS + YS > SH) begin
                                    ball_y_d = 9'(SH - BS);
                                    dir_y_d  = 1'b0;
                                end else begin
                                    ball_y_d = 9'(by + YS);
                                end
                            end
                        end
                    end
                end
                default: begin
                    // DONE: ball parked, scores frozen until start drops.
                    ball_x_d = CENTER_X;
                    ball_y_d = CENTER_Y;
                end
            endcase
        end
    end

    assign bus.ball_x      = ball_x_q;
    assign bus.ball_y      = ball_y_q;
    assign bus.p1_score    = p1_q;
    assign bus.p2_score    = p2_q;
    assign bus.state       = state_q;
    assign bus.score_pulse = pulse_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine
//   Directed, table-driven bench for pong_ball_engine (default build).
//   Each table record sets start/paddles, applies a number of frame ticks
//   (zero means one plain clk edge) and gives the hand-computed outputs.
module tb_pong_ball_engine;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pong_ball_engine_if bus ();

    pong_ball_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic       start;
        logic [8:0] p1y;
        logic [8:0] p2y;
        int         ticks;
        logic [1:0] e_state;
        logic [9:0] e_x;
        logic [8:0] e_y;
        logic [3:0] e_p1;
        logic [3:0] e_p2;
        logic       e_pulse;
    } vec_t;

    vec_t vec_q[$];

    function automatic void add(input logic s, input int a, input int b, input int n,
                                input int es, input int ex, input int ey,
                                input int e1, input int e2, input logic ep);
        vec_t v;
        v.start   = s;
        v.p1y     = 9'(a);
        v.p2y     = 9'(b);
        v.ticks   = n;
        v.e_state = 2'(es);
        v.e_x     = 10'(ex);
        v.e_y     = 9'(ey);
        v.e_p1    = 4'(e1);
        v.e_p2    = 4'(e2);
        v.e_pulse = ep;
        vec_q.push_back(v);
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge just after the tick edge.
    task automatic tick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vectors(input string tag);
        vec_t v;
        for (int i = 0; i < vec_q.size(); i++) begin
            v = vec_q[i];
            bus.start     = v.start;
            bus.paddle1_y = v.p1y;
            bus.paddle2_y = v.p2y;
            if (v.ticks == 0) @(negedge clk);
            else repeat (v.ticks) tick();
            chk($sformatf("%s[%0d] state", tag, i), int'(bus.state), int'(v.e_state));
            chk($sformatf("%s[%0d] ball_x", tag, i), int'(bus.ball_x), int'(v.e_x));
            chk($sformatf("%s[%0d] ball_y", tag, i), int'(bus.ball_y), int'(v.e_y));
            chk($sformatf("%s[%0d] p1_score", tag, i), int'(bus.p1_score), int'(v.e_p1));
            chk($sformatf("%s[%0d] p2_score", tag, i), int'(bus.p2_score), int'(v.e_p2));
            chk($sformatf("%s[%0d] score_pulse", tag, i), int'(bus.score_pulse), int'(v.e_pulse));
            if (v.e_pulse) begin
                @(negedge clk);
                chk($sformatf("%s[%0d] score_pulse fall", tag, i), int'(bus.score_pulse), 0);
            end
        end
        vec_q.delete();
    endtask

    // ---------------- stimulus and scoreboard ----------------
    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.frame_tick = 1'b0;
        bus.paddle1_y  = 9'd0;
        bus.paddle2_y  = 9'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Phase A: idle, serve, right reflection, left misses to DONE.
        //  start p1y p2y ticks state  x    y   p1 p2 pulse
        add(0,   0,   0,   0,  0, 316, 236, 0, 0, 0);
        add(0,   0,   0, 100,  0, 316, 236, 0, 0, 0);
        add(1,   0,   0,   1,  1, 316, 236, 0, 0, 0);
        add(1,   0,   0,  59,  1, 316, 236, 0, 0, 0);
        add(1,   0,   0,   1,  2, 316, 236, 0, 0, 0);
        add(1,   0,   0,   1,  2, 320, 238, 0, 0, 0);
        add(1,   0, 370,  75,  2, 620, 388, 0, 0, 0);
        add(1,   0, 370,   1,  2, 622, 390, 0, 0, 0);   // right paddle hit
        add(1,   0, 370,   1,  2, 618, 392, 0, 0, 0);
        add(1, 430, 370, 152,  2,  10, 250, 0, 0, 0);   // bounced off bottom
        add(1, 430, 370,   2,  2,   2, 246, 0, 0, 0);   // paddle missed
        add(1, 430, 370,   1,  1, 316, 236, 0, 1, 1);   // left miss
        add(1, 430, 370,  60,  2, 316, 236, 0, 1, 0);
        add(1, 430, 370,   1,  2, 312, 234, 0, 1, 0);   // serve goes left, up
        for (int r = 2; r <= 10; r++) begin
            add(1, 430, 370, 78, 2, 0, 78, 0, r - 1, 0);
            add(1, 430, 370, 1, (r == 10) ? 3 : 1, 316, 236, 0, r, 1);
            if (r < 10) begin
                add(1, 430, 370, 60, 2, 316, 236, 0, r, 0);
                add(1, 430, 370, 1, 2, 312, 234, 0, r, 0);
            end
        end
        add(1, 430, 370,  20,  3, 316, 236, 0, 10, 0);  // DONE, frozen
        add(0, 430, 370,   0,  0, 316, 236, 0, 0, 0);   // start drop, no tick
        run_vectors("A");

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Phase B: left reflection, top wall, right miss, start=0 with tick.
        add(1, 230, 370,   1,  1, 316, 236, 0, 0, 0);
        add(1, 230, 370,  59,  1, 316, 236, 0, 0, 0);
        add(1, 230, 370,   1,  2, 316, 236, 0, 0, 0);
        add(1, 230, 370,   1,  2, 320, 238, 0, 0, 0);
        add(1, 230, 370,  75,  2, 620, 388, 0, 0, 0);
        add(1, 230, 370,   1,  2, 622, 390, 0, 0, 0);
        add(1, 230, 370, 153,  2,  10, 250, 0, 0, 0);
        add(1, 230, 370,   1,  2,  10, 248, 0, 0, 0);   // left paddle hit
        add(1, 230, 370,   1,  2,  14, 246, 0, 0, 0);
        add(1, 230,   0, 151,  2, 618,  54, 0, 0, 0);   // via top wall
        add(1, 230,   0,   1,  2, 622,  56, 0, 0, 0);
        add(1, 230,   0,   2,  2, 630,  60, 0, 0, 0);   // no overlap, passes
        add(1, 230,   0,   1,  1, 316, 236, 1, 0, 1);   // right miss
        add(1, 230,   0,  60,  2, 316, 236, 1, 0, 0);
        add(1, 230,   0,   1,  2, 320, 238, 1, 0, 0);   // serve goes right
        add(0, 230,   0,   1,  0, 316, 236, 0, 0, 0);   // start drop beats tick
        run_vectors("B");

        // Asynchronous reset between clk edges during PLAY.
        bus.start = 1'b1;
        repeat (64) tick();
        chk("async pre ball_x", int'(bus.ball_x), 328);
        chk("async pre ball_y", int'(bus.ball_y), 242);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async state", int'(bus.state), 0);
        chk("async ball_x", int'(bus.ball_x), 316);
        chk("async ball_y", int'(bus.ball_y), 236);
        chk("async p1_score", int'(bus.p1_score), 0);
        chk("async p2_score", int'(bus.p2_score), 0);
        chk("async score_pulse", int'(bus.score_pulse), 0);
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_ball_engine.md
# pong_ball_engine

Frame-rate game-logic stage directly upstream of the pong top-level renderer. It owns the ball: position, direction, wall and paddle collisions, scoring and the game state machine. It consumes the two paddle Y positions produced by the potentiometer scaling logic. It drives the ball X/Y coordinates fed to the ball `object` instance, plus the score and state values shown on the LEDs and seven-segment display.

## Interface
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- BALL_SIZE, 8, ball width and height
- PADDLE_W, 10, paddle width; PADDLE_H, 50, paddle height
- P1_PADDLE_X, 0, left paddle X; P2_PADDLE_X, 630, right paddle X
- X_STEP, 4, horizontal pixels per frame; Y_STEP, 2, vertical pixels per frame
- X_STEP_MAX, 8, horizontal step ceiling (BALL_SPEEDUP_EN only)
- WIN_SCORE, 10, points that end the game
- SERVE_DELAY, 60, frame ticks the ball rests at centre before each serve

Ports:
- clk  in  1  pixel-domain clock (DIV_CLK[1])
- reset  in  1  asynchronous, active-high
- start  in  1  game enable level (Sw1)
- frame_tick  in  1  one-clk pulse per video frame
- paddle1_y  in  9  left paddle top Y
- paddle2_y  in  9  right paddle top Y
- ball_x  out  10  ball left X, registered
- ball_y  out  9  ball top Y, registered
- p1_score  out  4  left player score
- p2_score  out  4  right player score
- state  out  2  00 IDLE, 01 SERVE, 10 PLAY, 11 DONE
- score_pulse  out  1  one-clk pulse when a point is awarded

## Operation
- Reset values:
  - ball_x = (SCREEN_W−BALL_SIZE)/2 = 316; ball_y = (SCREEN_H−BALL_SIZE)/2 = 236
  - scores 0, state IDLE, score_pulse 0
  - dir_x right, dir_y down, serve counter 0, step = X_STEP
- IDLE: ball held at centre, scores held at 0. start=1 → SERVE.
- SERVE: ball held at centre. The counter increments per frame_tick. On the tick where the count reaches SERVE_DELAY → PLAY, counter cleared.
- PLAY: each frame_tick moves the ball by ±step in X and ±Y_STEP in Y. X and Y are resolved independently within the same tick.
  - Top wall: dir_y up and ball_y < Y_STEP → ball_y=0, dir_y=down.
  - Bottom wall: dir_y down and ball_y+BALL_SIZE+Y_STEP > SCREEN_H → ball_y=SCREEN_H−BALL_SIZE, dir_y=up.
  - Left paddle:
    - Applies when dir_x left and P1_PADDLE_X+PADDLE_W ≤ ball_x < P1_PADDLE_X+PADDLE_W+step.
    - Overlap test: ball_y+BALL_SIZE > paddle1_y and ball_y < paddle1_y+PADDLE_H.
    - On overlap: ball_x = P1_PADDLE_X+PADDLE_W, dir_x=right.
  - Right paddle: mirror of the left rule against P2_PADDLE_X−BALL_SIZE using paddle2_y.
  - Miss left: dir_x left and ball_x < step → p2_score+1.
  - Miss right: dir_x right and ball_x+BALL_SIZE+step > SCREEN_W → p1_score+1.
  - On any miss:
    - score_pulse=1 for one clk; ball recentred; step=X_STEP.
    - dir_x points toward the player who lost the point. dir_y is preserved.
    - New score = WIN_SCORE → DONE, else → SERVE.
- DONE: ball held at centre; scores frozen.
- start=0 in SERVE, PLAY or DONE → IDLE, with scores cleared and ball recentred. This takes priority over frame_tick in the same cycle.
- First serve after IDLE goes right.
- Arithmetic uses 11-bit intermediates so that no compare wraps. Scores saturate at WIN_SCORE.

## Timing
- All state changes occur on the clk edge where frame_tick=1, except start=0 → IDLE, which acts on any edge.
- Outputs are registered: they change one clk after the sampled frame_tick. Paddle inputs are sampled on that same edge.
- score_pulse rises on the scoring edge and falls on the next edge.
- The serve lasts exactly SERVE_DELAY ticks. The first ball movement happens on tick SERVE_DELAY+1.
- Reset is asynchronous: all outputs take their reset values immediately, without waiting for a clk edge.

## Configuration
- BALL_SPEEDUP_EN defined: each paddle reflection increments step by 1, saturating at X_STEP_MAX. Step returns to X_STEP on every serve.
- BALL_SPEEDUP_EN undefined: step is constant at X_STEP, and X_STEP_MAX is unused.

## Test plan
- Reset, start=0, 100 ticks → ball_x=316, ball_y=236, scores 0, state 00 throughout.
- start=1 → state 01 for 60 ticks with the ball static. Tick 61 → state 10, ball_x=320, ball_y=238.
- paddle2_y set to ball_y−20 every tick → ball reflects at ball_x=622, next tick 618, scores unchanged. With BALL_SPEEDUP_EN, after 4 alternating hits step=8 and stays 8 on the 5th hit.
- paddle1_y=430 while the ball travels left from mid-field → p2_score=1, one-clk score_pulse, ball at 316/236, state 01, next serve moves left.
- 10 consecutive left misses → p2_score=10, state 11, ball frozen. Then start=0 → state 00, scores 0.
- Assert reset mid-PLAY between clk edges → outputs reach reset values immediately, with no clk edge.
